// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
// Takes 18 joint angle commands into a shadow bank, applies them together at a
// frame boundary, slew-limits each joint's pulse width once per frame, and
// drives 18 hobby-servo PWM outputs on a fixed frame period.
module servo_pwm_driver #(
   parameter int TICK_DIV      = 50,
   parameter int FRAME_US      = 20000,
   parameter int PULSE_MIN_US  = 500,
   parameter int PULSE_SPAN_US = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [4:0]  cmd_index,
   input  logic [15:0] cmd_angle,
   input  logic        cmd_commit,
   input  logic [11:0] slew_step,
   output logic [17:0] pwm_out,
   output logic        frame_start,
   output logic        cmd_err,
   output logic        busy
);

   localparam int NJ     = 18;
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int US_W   = $clog2(FRAME_US);

   localparam logic [11:0]       W_RST     = 12'(PULSE_MIN_US + PULSE_SPAN_US / 2);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [US_W-1:0]   US_LAST   = US_W'(FRAME_US - 1);
   localparam logic [4:0]        J_LAST    = 5'd17;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      RUN    = 2'd2
   } state_t;

   // Angle to pulse width: coarse angle saturated at the span, offset by the
   // minimum width. The whole angle word enters the shift so no bits dangle.
   function automatic logic [11:0] map_width(input logic [15:0] angle);
      logic [15:0] coarse;
      coarse = angle >> 5;
      if (coarse > 16'(PULSE_SPAN_US))
         coarse = 16'(PULSE_SPAN_US);
      return 12'(16'(PULSE_MIN_US) + coarse);
   endfunction

   // Move c toward t by at most s; s == 0 means jump straight to t.
   // Differences are taken in 13-bit signed so nothing wraps.
   function automatic logic [11:0] slew_limit(input logic [11:0] c,
                                              input logic [11:0] t,
                                              input logic [11:0] s);
      logic signed [12:0] diff;
      logic signed [12:0] mag;
      logic signed [12:0] step_s;
      diff   = $signed({1'b0, t}) - $signed({1'b0, c});
      mag    = diff[12] ? -diff : diff;
      step_s = $signed({1'b0, s});
      if (s == 12'd0 || mag <= step_s)
         return t;
      else if (diff[12])
         return c - s;
      else
         return c + s;
   endfunction

   state_t            state;
   state_t            next_state;
   logic [TICK_W-1:0] tick_cnt;
   logic [US_W-1:0]   us_cnt;
   logic [4:0]        upd_idx;
   logic              commit_pending;
   logic [11:0]       shadow [NJ];
   logic [11:0]       target [NJ];
   logic [11:0]       cur    [NJ];

   logic              frame_end;
   logic              enter_upd;
   logic              wr_fire;
   logic              wr_ok;
   logic              do_copy;
   logic [11:0]       tgt_sel;

   assign cmd_ready = !rst && (state != UPDATE);
   assign busy      = (state == UPDATE);
   assign frame_end = (state == RUN) && (us_cnt == US_LAST) && (tick_cnt == TICK_LAST);
   assign enter_upd = (state != UPDATE) && (next_state == UPDATE);
   assign wr_fire   = cmd_valid && cmd_ready;
   assign wr_ok     = wr_fire && (cmd_index < 5'd18);
   // A commit arriving in the first UPDATE cycle is folded into this frame.
   assign do_copy   = (state == UPDATE) && enable && (upd_idx == 5'd0) &&
                      (commit_pending || cmd_commit);

   // Target for the joint being processed; joint 0 sees the bank being copied now.
   always_comb begin
      tgt_sel = target[upd_idx];
      if (do_copy)
         tgt_sel = shadow[upd_idx];
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // FSM next-state logic; dropping enable always returns to IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (enable)
               next_state = UPDATE;
         end
         UPDATE: begin
            if (!enable)
               next_state = IDLE;
            else if (upd_idx == J_LAST)
               next_state = RUN;
         end
         RUN: begin
            if (!enable)
               next_state = IDLE;
            else if (frame_end)
               next_state = UPDATE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Tick / microsecond counters and the UPDATE joint index; all restart at frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         us_cnt   <= '0;
         upd_idx  <= '0;
      end else if (next_state == IDLE || enter_upd) begin
         tick_cnt <= '0;
         us_cnt   <= '0;
         upd_idx  <= '0;
      end else begin
         if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            us_cnt   <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
         if (state == UPDATE && upd_idx != J_LAST)
            upd_idx <= upd_idx + 1'b1;
      end
   end

   // Shadow bank writes, commit latch, and the bank-wide shadow-to-target copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_pending <= 1'b0;
         for (int j = 0; j < NJ; j++) begin
            shadow[j] <= W_RST;
            target[j] <= W_RST;
         end
      end else begin
         if (wr_ok)
            shadow[cmd_index] <= map_width(cmd_angle);
         if (do_copy) begin
            commit_pending <= 1'b0;
            for (int j = 0; j < NJ; j++)
               target[j] <= shadow[j];
         end else if (cmd_commit) begin
            commit_pending <= 1'b1;
         end
      end
   end

   // One joint per UPDATE cycle steps its output width toward the target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NJ; j++)
            cur[j] <= W_RST;
      end else if (state == UPDATE && enable) begin
         cur[upd_idx] <= slew_limit(cur[upd_idx], tgt_sel, slew_step);
      end
   end

   // Registered outputs: pulse compare, frame-start strobe, bad-index strobe.
   // Compare is held off in IDLE so the first pulse after enable is not one cycle long.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out     <= '0;
         frame_start <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         for (int j = 0; j < NJ; j++)
            pwm_out[j] <= enable && (state != IDLE) && (32'(us_cnt) < 32'(cur[j]));
         frame_start <= enter_upd;
         cmd_err     <= wr_fire && (cmd_index > 5'd17);
      end
   end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Testbench for servo_pwm_driver: frame-level reference model feeds a queue of
// expected per-joint widths; a monitor measures each frame and compares.
module tb_servo_pwm_driver;

   localparam int TICK      = 20;
   localparam int FUS       = 80;
   localparam int PMIN      = 10;
   localparam int PSPAN     = 60;
   localparam int NJ        = 18;
   localparam int FRAME_CYC = FUS * TICK;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [4:0]  cmd_index = '0;
   logic [15:0] cmd_angle = '0;
   logic        cmd_commit = 1'b0;
   logic [11:0] slew_step = '0;
   logic [17:0] pwm_out;
   logic        frame_start;
   logic        cmd_err;
   logic        busy;

   servo_pwm_driver #(
      .TICK_DIV(TICK), .FRAME_US(FUS), .PULSE_MIN_US(PMIN), .PULSE_SPAN_US(PSPAN)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_angle(cmd_angle),
      .cmd_commit(cmd_commit), .slew_step(slew_step), .pwm_out(pwm_out),
      .frame_start(frame_start), .cmd_err(cmd_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_q[$];
   int err_q[$];

   // Reference model state (frame level)
   int m_shadow[NJ];
   int m_target[NJ];
   int m_cur[NJ];
   bit m_pending = 1'b0;
   int m_slew = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int ref_width(input int angle);
      int c;
      c = angle / 32;
      if (c > PSPAN) c = PSPAN;
      return PMIN + c;
   endfunction

   // Apply one frame boundary to the model and queue the widths expected in it.
   task automatic model_frame(input bit commit_now);
      if (m_pending || commit_now) begin
         for (int j = 0; j < NJ; j++) m_target[j] = m_shadow[j];
         m_pending = 1'b0;
      end
      for (int j = 0; j < NJ; j++) begin
         int d;
         d = m_target[j] - m_cur[j];
         if (m_slew == 0 || (d < 0 ? -d : d) <= m_slew)
            m_cur[j] = m_target[j];
         else
            m_cur[j] = m_cur[j] + (d > 0 ? m_slew : -m_slew);
         exp_q.push_back(m_cur[j]);
      end
   endtask

   task automatic wait_frame(input bit commit_now);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 2 * FRAME_CYC + 100; k++) begin
         @(negedge clk);
         if (frame_start) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check("frame_start_timeout", 0, 1);
         return;
      end
      if (commit_now) cmd_commit = 1'b1;
      model_frame(commit_now);
      if (commit_now) begin
         @(negedge clk);
         cmd_commit = 1'b0;
      end
   endtask

   task automatic do_write(input int idx, input int angle, input bit commit, output int waited);
      cmd_index = 5'(idx);
      cmd_angle = 16'(angle);
      cmd_valid = 1'b1;
      waited = 0;
      while (!cmd_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("write_ready_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      cmd_commit = commit;
      if (idx < NJ) m_shadow[idx] = ref_width(angle);
      else err_q.push_back(1);
      if (commit) m_pending = 1'b1;
      @(negedge clk);
      cmd_valid  = 1'b0;
      cmd_commit = 1'b0;
   endtask

   task automatic do_commit();
      cmd_commit = 1'b1;
      m_pending = 1'b1;
      @(negedge clk);
      cmd_commit = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: measures each complete frame and checks it against the queue.
   bit meas = 1'b0;
   int hi[NJ];
   int cyc;
   int bcnt;
   always @(negedge clk) begin
      if (cmd_err) begin
         check("cmd_err_expected", int'(err_q.size() > 0), 1);
         if (err_q.size() > 0) void'(err_q.pop_front());
      end
      if (rst || !enable) begin
         if (meas) begin
            for (int j = 0; j < NJ && exp_q.size() > 0; j++) void'(exp_q.pop_front());
            meas = 1'b0;
         end
      end else begin
         if (frame_start) begin
            if (meas) begin
               check("exp_queue_depth", int'(exp_q.size() >= NJ), 1);
               for (int j = 0; j < NJ; j++) begin
                  int e;
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                  check($sformatf("width_cycles_j%0d", j), hi[j], e * TICK);
               end
               check("frame_len", cyc, FRAME_CYC);
               check("busy_len", bcnt, 18);
            end
            meas = 1'b1;
            cyc = 0;
            bcnt = 0;
            for (int j = 0; j < NJ; j++) hi[j] = 0;
         end
         if (meas) begin
            cyc++;
            bcnt += int'(busy);
            for (int j = 0; j < NJ; j++) hi[j] += int'(pwm_out[j]);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int j = 0; j < NJ; j++) begin
         m_shadow[j] = PMIN + PSPAN / 2;
         m_target[j] = PMIN + PSPAN / 2;
         m_cur[j]    = PMIN + PSPAN / 2;
      end

      // Reset values
      #2 rst = 1'b1;
      idle(3);
      check("rst_pwm_out", int'(pwm_out), 0);
      check("rst_cmd_ready", int'(cmd_ready), 0);
      check("rst_frame_start", int'(frame_start), 0);
      check("rst_cmd_err", int'(cmd_err), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      idle(2);
      check("idle_cmd_ready", int'(cmd_ready), 1);

      // Default widths
      slew_step = 12'd0; m_slew = 0;
      enable = 1'b1;
      wait_frame(0);
      wait_frame(0);

      // Joint 4 to full scale, write and commit in the same cycle
      idle(40);
      do_write(4, 16'hFFFF, 1'b1, w);
      wait_frame(0);
      wait_frame(0);

      // Joint 0 to angle 0 with slew limit
      idle(40);
      slew_step = 12'd12; m_slew = 12;
      do_write(0, 0, 1'b1, w);
      repeat (5) wait_frame(0);
      slew_step = 12'd0; m_slew = 0;

      // Write without commit, then commit on the frame_start cycle
      idle(40);
      do_write(7, 16'h0300, 1'b0, w);
      wait_frame(0);
      wait_frame(0);
      wait_frame(1);

      // Write issued during UPDATE is held off until busy falls; bad index
      wait_frame(0);
      check("ready_during_busy", int'(cmd_ready), 0);
      do_write(9, 16'h0500, 1'b1, w);
      check("holdoff_cycles", w, 18);
      do_write(20, 16'h1234, 1'b0, w);
      wait_frame(0);

      // Randomized frames
      repeat (8) begin
         int nw, mode;
         idle(40);
         m_slew = $urandom_range(0, 20);
         slew_step = 12'(m_slew);
         nw = $urandom_range(0, 4);
         for (int i = 0; i < nw; i++)
            do_write($urandom_range(0, 19), $urandom_range(0, (PSPAN + 5) * 32),
                     ($urandom_range(0, 3) == 0), w);
         mode = $urandom_range(0, 2);
         if (mode == 1) do_commit();
         wait_frame(mode == 2);
      end

      // Enable dropped mid-frame and restored
      idle(20 * TICK);
      enable = 1'b0;
      @(negedge clk);
      check("pwm_off_after_disable", int'(pwm_out), 0);
      check("idle_not_busy", int'(busy), 0);
      idle(5 * TICK);
      enable = 1'b1;
      wait_frame(0);
      wait_frame(0);

      // Asynchronous reset mid-frame
      idle(300);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pwm_out", int'(pwm_out), 0);
      check("async_rst_cmd_ready", int'(cmd_ready), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_frame_start", int'(frame_start), 0);
      idle(3);
      check("exp_queue_drained", exp_q.size(), 0);
      check("err_queue_drained", err_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/servo_pwm_driver.md
# servo_pwm_driver

Downstream stage of the gait calculator: accepts the 18 joint angle commands (6 legs × 3 joints), limits how fast each one can change, and drives 18 hobby-servo PWM outputs on a fixed 20 ms frame. Commands land in a shadow bank and take effect together at a frame boundary, so every joint of a gait step updates in the same frame. Slew limiting smooths step changes coming from the phase-based gait computation.

## Interface
Parameters:
- TICK_DIV, 50: clk cycles per 1 µs tick. Must be ≥ 20.
- FRAME_US, 20000: frame length in µs.
- PULSE_MIN_US, 500: pulse width for angle 0.
- PULSE_SPAN_US, 2000: maximum width above PULSE_MIN_US.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  1 = generate PWM; 0 = outputs low and frame counters held at 0
- cmd_valid  in  1  command write strobe
- cmd_ready  out  1  block accepts a write this cycle
- cmd_index  in  5  joint 0..17 (leg*3 + joint)
- cmd_angle  in  16  target angle, same encoding as gait calculator output
- cmd_commit  in  1  one-cycle pulse: apply the shadow bank at the next frame start
- slew_step  in  12  maximum width change per frame, in µs; 0 = no limit
- pwm_out  out  18  servo pulses, bit j = joint j
- frame_start  out  1  one-cycle pulse at each frame start
- cmd_err  out  1  one-cycle pulse when a write with cmd_index > 17 is accepted
- busy  out  1  high while in UPDATE

## Operation
- Angle mapping: width = PULSE_MIN_US + min(cmd_angle >> 5, PULSE_SPAN_US), computed at write time. Stored per joint as a 12-bit µs value in shadow[j].
- Write: on cmd_valid & cmd_ready, shadow[cmd_index] <= mapped width. If cmd_index > 17, nothing is written and cmd_err pulses on the next cycle.
- cmd_commit sets commit_pending. Further commits while pending have no extra effect.
- Registers:
  - target[j]: goal width.
  - cur[j]: width currently output.
  - After reset, shadow, target and cur are all PULSE_MIN_US + PULSE_SPAN_US/2 (1500 with default parameters).
- State machine states: IDLE, UPDATE, RUN.
  - IDLE: entered on reset and whenever enable = 0. Goes to UPDATE on the first cycle with enable = 1.
  - UPDATE: lasts exactly 18 cycles, processing j = 0..17 in order, one joint per cycle.
    - Cycle 0: if commit_pending, copy all shadow entries into target and clear commit_pending.
    - For joint j: if slew_step == 0 or |target − cur| ≤ slew_step, then cur[j] <= target[j]. Otherwise cur[j] moves toward target[j] by slew_step.
    - Arithmetic is 13-bit signed, so there is no wrap.
    - Goes to RUN after joint 17.
  - RUN: the µs counter runs. At us_cnt == FRAME_US−1 with tick_cnt == TICK_DIV−1, the frame ends and the FSM goes to UPDATE.
- Counters:
  - tick_cnt runs 0..TICK_DIV−1 and wraps.
  - us_cnt increments when tick_cnt wraps and wraps to 0 at FRAME_US.
  - Both counters start at 0 on the cycle the FSM enters UPDATE and keep running through UPDATE.
- PWM output: pwm_out[j] <= enable & (us_cnt < cur[j]), registered.
  - Because TICK_DIV ≥ 20, UPDATE finishes inside µs 0. The minimum width of 500 µs means the new cur[] is always in effect before any compare edge.
- cmd_ready = 0 during UPDATE and while rst is high; 1 otherwise.
- enable deasserted mid-frame:
  - On the next cycle pwm_out = 0 and the FSM is in IDLE.
  - target, cur, shadow and commit_pending are all kept.

## Timing
- Reset values: pwm_out = 0, cmd_ready = 0, frame_start = 0, cmd_err = 0, busy = 0, state = IDLE, commit_pending = 0.
- frame_start is high on the cycle the FSM enters UPDATE.
- busy is high for exactly 18 cycles, aligned with UPDATE.
- Write-to-output latency: a write followed by a commit takes effect at the next frame start. The first pulse edge reflecting it falls in that frame.
- Simultaneous events:
  - cmd_commit on the frame_start cycle is consumed by that UPDATE, because commit_pending is sampled combinationally with the pulse.
  - A write and a commit in the same cycle: the write is included in the commit.
  - A write with no commit only updates shadow.
- Frame length is exactly FRAME_US·TICK_DIV clk cycles between frame_start pulses (1,000,000 with default parameters).
- Reset asserted mid-frame: all outputs reach their reset values asynchronously.

## Test plan
- Reset then enable = 1: frame_start pulses every 1,000,000 cycles. Every pwm_out bit is high for 1500·50 cycles per frame.
- Write joint 4 with angle 16'hFFFF and commit, slew_step = 0: from the next frame, pwm_out[4] is high for 2500 µs; the other bits stay at 1500 µs.
- Write joint 0 with angle 0 and commit, slew_step = 300: joint 0 widths per frame are 1200, 900, 600, 500, 500 µs.
- Write without commit: outputs unchanged over 3 frames. Commit asserted on the frame_start cycle takes effect in that same frame.
- cmd_index = 20: cmd_err pulses once and no width changes. Writes issued during busy are held off (cmd_ready = 0) and are accepted once busy falls.
- enable dropped at µs 700 and restored 5 µs later: pwm_out = 0 the next cycle, and a new frame_start follows on re-enable. cur[] values are preserved.
